// File: rtl/bresenham_scan.sv
// bresenham_scan: flat-bottom triangle rasterizer emitting one span per row to a fill stage.
// Ports: clk, rst (sync active-low); start with vertices v0_xy (top), v1_xy/v2_xy (bottom
// ends of edges A/B, {x,y}) and color; ack_2 from the fill stage. Outputs req_2 (span
// strobe), point_out_a_x, point_out_b_xy ({xb,y}), rgb, busy, done, error.
module bresenham_scan (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] v0_xy,
  input  logic [15:0] v1_xy,
  input  logic [15:0] v2_xy,
  input  logic [23:0] color,
  input  logic        ack_2,
  output logic        req_2,
  output logic [7:0]  point_out_a_x,
  output logic [15:0] point_out_b_xy,
  output logic [23:0] rgb,
  output logic        busy,
  output logic        done,
  output logic        error
);
  typedef enum logic [2:0] {IDLE, REQ, HOLD, STEP_A, STEP_B, DONE} state_t;
  state_t state_q, state_d;
  logic [7:0] xa_q, xa_d, xb_q, xb_d, y_q, y_d;
  logic [7:0] x1_q, x1_d, y1_q, y1_d, x2_q, x2_d;
  logic [7:0] dxa_q, dxa_d, dxb_q, dxb_d, dy_q, dy_d;
  logic sxa_q, sxa_d, sxb_q, sxb_d, bad_q, bad_d;
  logic signed [10:0] erra_q, erra_d, errb_q, errb_d;
  logic [23:0] rgb_q, rgb_d;
  logic [7:0] x0, y0, x1, y1, x2, y2, dxa, dxb;
  logic signed [11:0] e2a, e2b;
  logic mova, adva, movb, advb;
  assign x0 = v0_xy[15:8];
  assign y0 = v0_xy[7:0];
  assign x1 = v1_xy[15:8];
  assign y1 = v1_xy[7:0];
  assign x2 = v2_xy[15:8];
  assign y2 = v2_xy[7:0];
  assign dxa = x1 >= x0 ? x1 - x0 : x0 - x1;
  assign dxb = x2 >= x0 ? x2 - x0 : x0 - x2;
  // 2*err in one extra bit keeps the sign exact
  assign e2a = $signed({erra_q, 1'b0});
  assign e2b = $signed({errb_q, 1'b0});
  assign mova = e2a > -$signed({4'd0, dy_q});
  assign adva = e2a < $signed({4'd0, dxa_q});
  assign movb = e2b > -$signed({4'd0, dy_q});
  assign advb = e2b < $signed({4'd0, dxb_q});
  // the last row is pinned to the true endpoints regardless of accumulated x
  assign point_out_a_x = y_q == y1_q ? x1_q : xa_q;
  assign point_out_b_xy = {y_q == y1_q ? x2_q : xb_q, y_q};
  assign rgb = rgb_q;
  assign req_2 = state_q == REQ;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign error = done & bad_q;
  always_comb begin
    state_d = state_q;
    xa_d = xa_q;
    xb_d = xb_q;
    y_d = y_q;
    x1_d = x1_q;
    y1_d = y1_q;
    x2_d = x2_q;
    dxa_d = dxa_q;
    dxb_d = dxb_q;
    dy_d = dy_q;
    sxa_d = sxa_q;
    sxb_d = sxb_q;
    erra_d = erra_q;
    errb_d = errb_q;
    rgb_d = rgb_q;
    bad_d = bad_q;
    unique case (state_q)
      IDLE: if (start) begin
        xa_d = x0;
        xb_d = x0;
        y_d = y0;
        x1_d = x1;
        y1_d = y1;
        x2_d = x2;
        dxa_d = dxa;
        dxb_d = dxb;
        dy_d = y1 - y0;
        sxa_d = x1 < x0;
        sxb_d = x2 < x0;
        erra_d = $signed({3'd0, dxa}) - $signed({3'd0, y1 - y0});
        errb_d = $signed({3'd0, dxb}) - $signed({3'd0, y1 - y0});
        rgb_d = color;
        bad_d = y1 != y2 || y1 < y0;
        state_d = bad_d ? DONE : REQ;
      end
      REQ: state_d = ack_2 ? HOLD : REQ;
      HOLD: state_d = ack_2 ? HOLD : y_q == y1_q ? DONE : STEP_A;
      STEP_A: begin
        erra_d = erra_q - (mova ? $signed({3'd0, dy_q}) : 11'sd0) + (adva ? $signed({3'd0, dxa_q}) : 11'sd0);
        xa_d = mova ? (sxa_q ? xa_q - 8'd1 : xa_q + 8'd1) : xa_q;
        state_d = adva ? STEP_B : STEP_A;
      end
      STEP_B: begin
        errb_d = errb_q - (movb ? $signed({3'd0, dy_q}) : 11'sd0) + (advb ? $signed({3'd0, dxb_q}) : 11'sd0);
        xb_d = movb ? (sxb_q ? xb_q - 8'd1 : xb_q + 8'd1) : xb_q;
        y_d = advb ? y_q + 8'd1 : y_q;
        state_d = advb ? REQ : STEP_B;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      xa_q <= '0;
      xb_q <= '0;
      y_q <= '0;
      x1_q <= '0;
      y1_q <= '0;
      x2_q <= '0;
      dxa_q <= '0;
      dxb_q <= '0;
      dy_q <= '0;
      sxa_q <= 1'b0;
      sxb_q <= 1'b0;
      erra_q <= '0;
      errb_q <= '0;
      rgb_q <= '0;
      bad_q <= 1'b0;
    end else begin
      state_q <= state_d;
      xa_q <= xa_d;
      xb_q <= xb_d;
      y_q <= y_d;
      x1_q <= x1_d;
      y1_q <= y1_d;
      x2_q <= x2_d;
      dxa_q <= dxa_d;
      dxb_q <= dxb_d;
      dy_q <= dy_d;
      sxa_q <= sxa_d;
      sxb_q <= sxb_d;
      erra_q <= erra_d;
      errb_q <= errb_d;
      rgb_q <= rgb_d;
      bad_q <= bad_d;
    end
  end
endmodule

// File: tb/tb_bresenham_scan.sv
// tb_bresenham_scan: randomized and directed checks of bresenham_scan against a line-drawing model.
module tb_bresenham_scan;
  logic clk = 0;
  logic rst = 0;
  logic start = 0;
  logic ack_2 = 0;
  logic [15:0] v0_xy = 0, v1_xy = 0, v2_xy = 0;
  logic [23:0] color = 0;
  logic req_2, busy, done, error;
  logic [7:0] point_out_a_x;
  logic [15:0] point_out_b_xy;
  logic [23:0] rgb;
  int checks = 0;
  int errors = 0;
  int xa_m[256], xb_m[256], sa_m[256], sb_m[256];
  bresenham_scan dut (
    .clk(clk), .rst(rst), .start(start), .v0_xy(v0_xy), .v1_xy(v1_xy), .v2_xy(v2_xy),
    .color(color), .ack_2(ack_2), .req_2(req_2), .point_out_a_x(point_out_a_x),
    .point_out_b_xy(point_out_b_xy), .rgb(rgb), .busy(busy), .done(done), .error(error)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  // textbook integer line walk; x of a row is the first point plotted on it
  task automatic model(input int x0, input int y0, input int x1, input int y1, input bit b);
    int dx, dy, sx, err, x, y, n, e2;
    dx = x1 >= x0 ? x1 - x0 : x0 - x1;
    dy = y1 - y0;
    sx = x1 >= x0 ? 1 : -1;
    err = dx - dy;
    x = x0;
    y = y0;
    n = 0;
    if (b) xb_m[y0] = x0; else xa_m[y0] = x0;
    while (y < y1) begin
      e2 = 2 * err;
      n++;
      if (e2 > -dy) begin
        err -= dy;
        x += sx;
      end
      if (e2 < dx) begin
        err += dx;
        y++;
        if (b) begin xb_m[y] = x; sb_m[y-1] = n; end
        else begin xa_m[y] = x; sa_m[y-1] = n; end
        n = 0;
      end
    end
    if (b) xb_m[y1] = x1; else xa_m[y1] = x1;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_req"}, req_2, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_err"}, error, 0);
    chk({tag, "_ax"}, point_out_a_x, 0);
    chk({tag, "_bxy"}, point_out_b_xy, 0);
    chk({tag, "_rgb"}, rgb, 0);
  endtask
  task automatic run_tri(input int x0, input int y0, input int x1, input int y1,
                         input int x2, input int y2, input int hold, input int abort_row);
    logic [23:0] c;
    logic [7:0] rr;
    bit bad;
    int w, gap;
    c = 24'($urandom);
    bad = (y1 != y2) || (y1 < y0);
    @(negedge clk);
    v0_xy = {x0[7:0], y0[7:0]};
    v1_xy = {x1[7:0], y1[7:0]};
    v2_xy = {x2[7:0], y2[7:0]};
    color = c;
    start = 1;
    @(negedge clk);
    start = 0;
    v0_xy = 16'($urandom);
    if (bad) begin
      chk("bad_req", req_2, 0);
      chk("bad_done", done, 1);
      chk("bad_error", error, 1);
      @(negedge clk);
      chk("bad_done_end", done, 0);
      chk("bad_error_end", error, 0);
      chk("bad_busy_end", busy, 0);
      return;
    end
    model(x0, y0, x1, y1, 0);
    model(x0, y0, x2, y2, 1);
    chk("latency", req_2, 1);
    for (int r = y0; r <= y1; r++) begin
      rr = r[7:0];
      w = 0;
      while (!req_2 && w < 1000) begin
        @(negedge clk);
        w++;
      end
      chk("req_timeout", req_2, 1);
      if (!req_2) return;
      for (int k = 0; k <= hold; k++) begin
        chk("req_hi", req_2, 1);
        chk("span_ax", point_out_a_x, xa_m[r]);
        chk("span_bxy", point_out_b_xy, {xb_m[r][7:0], rr});
        chk("span_rgb", rgb, c);
        if (k == hold) break;
        start = 1'($urandom);
        v0_xy = 16'($urandom);
        v1_xy = 16'($urandom);
        @(negedge clk);
      end
      start = 0;
      ack_2 = 1;
      @(negedge clk);
      chk("req_fall", req_2, 0);
      chk("hold_ax", point_out_a_x, xa_m[r]);
      chk("hold_bxy", point_out_b_xy, {xb_m[r][7:0], rr});
      if (r == abort_row) begin
        rst = 0;
        @(negedge clk);
        rst = 1;
        ack_2 = 0;
        chk_zero("abort");
        return;
      end
      repeat ($urandom % 3) @(negedge clk);
      ack_2 = 0;
      gap = 0;
      forever begin
        @(negedge clk);
        if (req_2 || done || gap > 2000) break;
        gap++;
      end
      if (r < y1) chk("step_cycles", gap, sa_m[r] + sb_m[r]);
      else begin
        chk("last_gap", gap, 0);
        chk("done", done, 1);
        chk("done_error", error, 0);
      end
    end
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1;
    run_tri(10, 5, 4, 8, 20, 8, 2, -1);
    run_tri(10, 5, 4, 8, 20, 8, 50, -1);
    run_tri(7, 0, 7, 2, 7, 2, 1, -1);
    run_tri(3, 9, 1, 9, 6, 9, 1, -1);
    run_tri(10, 5, 4, 8, 20, 7, 0, -1);
    run_tri(10, 5, 4, 3, 20, 3, 0, -1);
    run_tri(10, 5, 4, 8, 20, 8, 1, 6);
    run_tri(10, 5, 4, 8, 20, 8, 1, -1);
    for (int i = 0; i < 25; i++) begin
      int y0, h, y2;
      y0 = $urandom % 200;
      h = $urandom % 7;
      y2 = ($urandom % 6 == 0) ? y0 + h + 1 : y0 + h;
      run_tri($urandom % 256, y0, $urandom % 256, y0 + h, $urandom % 256, y2, $urandom % 3, -1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/bresenham_scan.md
BRESENHAM_SCAN -- requirements
Module: bresenham_scan

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-low reset; all state SHALL change only on the rising edge of clk.
REQ-002 Port clk, input, 1 bit: system clock.
REQ-003 Port rst, input, 1 bit: synchronous active-low reset.
REQ-004 Port start, input, 1 bit: start request; sampled only in IDLE.
REQ-005 Port v0_xy, input, 16 bits: top vertex, packed as {x[15:8], y[7:0]}.
REQ-006 Ports v1_xy and v2_xy, input, 16 bits each: bottom vertices of edge A and edge B, packed as {x, y}.
REQ-007 Port color, input, 24 bits: {r, g, b}; latched when start is accepted.
REQ-008 Port ack_2, input, 1 bit: fill-stage acknowledge; high while the fill stage is consuming a span.
REQ-009 Port req_2, output, 1 bit: span-request strobe to the fill stage.
REQ-010 Port point_out_a_x, output, 8 bits: edge-A x of the current row.
REQ-011 Port point_out_b_xy, output, 16 bits: {edge-B x, current row y}.
REQ-012 Port rgb, output, 24 bits: latched color.
REQ-013 Ports busy, done and error, output, 1 bit each: busy high outside IDLE; done is a 1-cycle pulse; error is a 1-cycle pulse coincident with done.

Function
REQ-014 The block SHALL rasterize a flat-bottom triangle: for each row y0..y1, it SHALL emit one span whose endpoints are the current edge-A x and edge-B x.
REQ-015 The FSM SHALL have the states IDLE, REQ, HOLD, STEP_A, STEP_B and DONE.
REQ-016 In IDLE with start=1, the block SHALL latch the vertices and color.
- If y1!=y2 or y1<y0, the next state SHALL be DONE with error asserted.
- Otherwise the next state SHALL be REQ.
REQ-017 Per-edge setup (computed from the latched inputs):
- dx=|x1-x0|, dy=y1-y0, sx=+1 if x1>=x0 else -1.
- err=dx-dy, held as an 11-bit signed value.
REQ-018 On the first row, x SHALL equal x0 for both edges.
REQ-019 REQ: req_2=1 and all outputs stable.
- ack_2=1 SHALL move the FSM to HOLD.
- Otherwise the FSM SHALL stay in REQ indefinitely.
REQ-020 HOLD: req_2=0, with point_out_a_x, point_out_b_xy and rgb unchanged.
- On ack_2=0: if row y==y1 the next state SHALL be DONE; otherwise STEP_A.
REQ-021 STEP_A SHALL perform one Bresenham iteration per cycle on edge A:
- e2=2*err.
- If e2>-dy: err-=dy and x+=sx.
- If e2<dx: err+=dx and the row advances.
- The FSM SHALL remain in STEP_A until the row advances, then go to STEP_B.
REQ-022 STEP_B SHALL perform the identical iteration on edge B until its row advances, then go to REQ with y incremented by 1.
REQ-023 On the final row (y==y1), point_out_a_x SHALL equal x1 and the edge-B x SHALL equal x2, regardless of the Bresenham x.
REQ-024 Degenerate case y0==y1==y2: exactly one span, with point_out_a_x=x1 and point_out_b_xy={x2, y0}.
REQ-025 Vertical edge (dx=0): the edge SHALL take exactly 1 step cycle per row.
REQ-026 DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-027 start SHALL be ignored while busy=1.
REQ-028 req_2 SHALL fall no later than the cycle after ack_2 is first seen high, so the fill stage never re-triggers on the same span.
REQ-029 Latency: with start accepted at edge t, req_2 SHALL be high in the cycle following edge t.

Reset
REQ-030 When rst=0 at any clock edge, including mid-span or mid-step, the block SHALL go to IDLE, and req_2, busy, done, error, point_out_a_x, point_out_b_xy and rgb SHALL all be 0 after that edge.
REQ-031 After reset the block SHALL accept a new start with no residual state.

Verification
REQ-032 v0=(10,5), v1=(4,8), v2=(20,8), with the fill model acking -> exactly 4 spans: (a=10, b=10, y=5), (8, 12, 6), (6, 16, 7), (4, 20, 8); then a done pulse with error=0.
REQ-033 Same triangle with ack_2 held at 0 for 50 cycles -> req_2 high and outputs constant for all 50 cycles, and no step states entered.
REQ-034 v0=(7,0), v1=(7,2), v2=(7,2) -> spans (7,7,0), (7,7,1), (7,7,2), with exactly 1 STEP_A and 1 STEP_B cycle between consecutive rows.
REQ-035 v0=(3,9), v1=(1,9), v2=(6,9) -> a single span a=1, b_xy={6,9}, then done.
REQ-036 v1 y=8, v2 y=7 -> req_2 never asserted; done=1 and error=1 for 1 cycle, 1 cycle after start.
REQ-037 rst=0 asserted while in HOLD during the row-6 span of the REQ-032 triangle -> all outputs 0 next cycle; a subsequent start reproduces the full REQ-032 sequence.
